seizure_event_detector: RTL and testbench

Post-processing stage directly downstream of the HDC classifier. Consumes one predicted label per encoded window, qualified by the encoder's window-valid strobe. Smooths the label stream with a sliding k-of-n vote and converts it into a debounced seizure flag with onset/offset pulses, minimum event duration, and a refractory period. Also keeps window and event counters for host readout.

---
 rtl/seizure_event_detector.sv | 132 +++++++++++++
 tb/tb_seizure_event_detector.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seizure_event_detector.sv
// Smooths per-window classifier labels with a k-of-n vote and turns them into a
// debounced seizure flag with onset/offset pulses. Optional: SEIZURE_TIMESTAMP_EN.
module seizure_event_detector #(
  parameter int VOTE_LEN          = 8,
  parameter int ON_THRESH         = 6,
  parameter int OFF_THRESH        = 2,
  parameter int MIN_EVENT_WINDOWS = 4,
  parameter int REFRACT_WINDOWS   = 4,
  parameter int CNT_W             = 16,
  localparam int VW               = $clog2(VOTE_LEN+1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             predicted_label,
  output logic             seizure_flag,
  output logic             onset_pulse,
  output logic             offset_pulse,
  output logic [VW-1:0]    vote_count,
  output logic [CNT_W-1:0] window_count,
  output logic [CNT_W-1:0] event_count,
  output logic [CNT_W-1:0] onset_window
);

  localparam int DW = $clog2(MIN_EVENT_WINDOWS+1);
  localparam int RW = (REFRACT_WINDOWS < 1) ? 1 : $clog2(REFRACT_WINDOWS+1);

  localparam logic [VW-1:0] FILL_FULL = VW'(VOTE_LEN);
  localparam logic [VW-1:0] ON_TH     = VW'(ON_THRESH);
  localparam logic [VW-1:0] OFF_TH    = VW'(OFF_THRESH);
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_EVENT_WINDOWS);
  localparam logic [RW-1:0] REF_INIT  = RW'(REFRACT_WINDOWS);
  localparam logic [RW-1:0] REF_ONE   = RW'(1);

  typedef enum logic [1:0] {NORMAL, SEIZURE, REFRACTORY} state_t;

  state_t            state, state_nxt;
  logic [VOTE_LEN-1:0] hist, hist_nxt;
  logic [VW-1:0]     vote_nxt;
  logic [VW-1:0]     fill, fill_nxt;
  logic [DW-1:0]     dwell, dwell_nxt, dwell_inc;
  logic [RW-1:0]     ref_cnt, ref_nxt;
  logic              onset, offset;
  logic [CNT_W-1:0]  win_nxt;

  // window index this edge would report; also the onset timestamp source
  assign win_nxt = (&window_count) ? window_count : window_count + 1'b1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= NORMAL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hist_nxt  = hist;
    vote_nxt  = vote_count;
    fill_nxt  = fill;
    dwell_nxt = dwell;
    dwell_inc = (dwell == DWELL_MAX) ? dwell : dwell + 1'b1;
    ref_nxt   = ref_cnt;
    onset     = 1'b0;
    offset    = 1'b0;
    if (en) begin
      // oldest label sits in the MSB; vote tracks the shift incrementally
      hist_nxt = {hist[VOTE_LEN-2:0], predicted_label};
      vote_nxt = vote_count + VW'(predicted_label) - VW'(hist[VOTE_LEN-1]);
      fill_nxt = (fill == FILL_FULL) ? fill : fill + 1'b1;
      case (state)
        NORMAL: begin
          if (fill_nxt == FILL_FULL && vote_nxt >= ON_TH) begin
            state_nxt = SEIZURE;
            onset     = 1'b1;
            dwell_nxt = '0;
          end
        end
        SEIZURE: begin
          dwell_nxt = dwell_inc;
          if (dwell_inc >= DWELL_MAX && vote_nxt <= OFF_TH) begin
            offset  = 1'b1;
            ref_nxt = REF_INIT;
            state_nxt = (REFRACT_WINDOWS == 0) ? NORMAL : REFRACTORY;
          end
        end
        REFRACTORY: begin
          // onset is never evaluated here, even on the final refractory window
          ref_nxt = ref_cnt - 1'b1;
          if (ref_cnt == REF_ONE) state_nxt = NORMAL;
        end
        default: state_nxt = NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hist         <= '0;
      vote_count   <= '0;
      fill         <= '0;
      dwell        <= '0;
      ref_cnt      <= '0;
      seizure_flag <= 1'b0;
      onset_pulse  <= 1'b0;
      offset_pulse <= 1'b0;
      window_count <= '0;
      event_count  <= '0;
    end else begin
      onset_pulse  <= onset;
      offset_pulse <= offset;
      if (en) begin
        hist         <= hist_nxt;
        vote_count   <= vote_nxt;
        fill         <= fill_nxt;
        dwell        <= dwell_nxt;
        ref_cnt      <= ref_nxt;
        seizure_flag <= (state_nxt == SEIZURE);
        window_count <= win_nxt;
        if (onset && !(&event_count)) event_count <= event_count + 1'b1;
      end
    end
  end

`ifdef SEIZURE_TIMESTAMP_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)      onset_window <= '0;
    else if (onset) onset_window <= win_nxt;
  end
`else
  assign onset_window = '0;
`endif

endmodule

// File: tb/tb_seizure_event_detector.sv
// Randomized bench for seizure_event_detector against a queue-based reference model.
module tb_seizure_event_detector;
  localparam int VOTE_LEN = 8, ON_T = 6, OFF_T = 2, MIN_EV = 4, REF_W = 4, CNT_W = 16;
  localparam int VW = $clog2(VOTE_LEN+1);

  logic clk = 1'b0, nrst = 1'b0, en = 1'b0, predicted_label = 1'b0;
  logic seizure_flag, onset_pulse, offset_pulse;
  logic [VW-1:0] vote_count;
  logic [CNT_W-1:0] window_count, event_count, onset_window;

  seizure_event_detector #(.VOTE_LEN(VOTE_LEN), .ON_THRESH(ON_T), .OFF_THRESH(OFF_T),
    .MIN_EVENT_WINDOWS(MIN_EV), .REFRACT_WINDOWS(REF_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst), .en(en), .predicted_label(predicted_label),
    .seizure_flag(seizure_flag), .onset_pulse(onset_pulse), .offset_pulse(offset_pulse),
    .vote_count(vote_count), .window_count(window_count), .event_count(event_count),
    .onset_window(onset_window));

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // reference model: label queue plus a phase (0 normal, 1 seizure, 2 refractory)
  int q[$];
  int m_win, m_ev, m_ow, m_phase, m_since_on, m_ref_left;
  bit m_on, m_off;

  function automatic int qsum();
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic model_reset();
    q.delete();
    m_win = 0; m_ev = 0; m_ow = 0; m_phase = 0; m_since_on = 0; m_ref_left = 0;
    m_on = 0; m_off = 0;
  endtask

  task automatic model_step(input bit e, input bit lab);
    int v;
    m_on = 0; m_off = 0;
    if (!e) return;
    q.push_back(int'(lab));
    if (q.size() > VOTE_LEN) void'(q.pop_front());
    v = qsum();
    if (m_win < (1 << CNT_W) - 1) m_win++;
    if (m_phase == 0) begin
      if (q.size() == VOTE_LEN && v >= ON_T) begin
        m_phase = 1; m_on = 1; m_since_on = 0; m_ow = m_win;
        if (m_ev < (1 << CNT_W) - 1) m_ev++;
      end
    end else if (m_phase == 1) begin
      m_since_on++;
      if (m_since_on >= MIN_EV && v <= OFF_T) begin
        m_off = 1;
        m_ref_left = REF_W;
        m_phase = (REF_W == 0) ? 0 : 2;
      end
    end else begin
      m_ref_left--;
      if (m_ref_left == 0) m_phase = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".flag"}, int'(seizure_flag), int'(m_phase == 1));
    chk({tag, ".onp"}, int'(onset_pulse), int'(m_on));
    chk({tag, ".offp"}, int'(offset_pulse), int'(m_off));
    chk({tag, ".vote"}, int'(vote_count), qsum());
    chk({tag, ".win"}, int'(window_count), m_win);
    chk({tag, ".ev"}, int'(event_count), m_ev);
`ifdef SEIZURE_TIMESTAMP_EN
    chk({tag, ".ow"}, int'(onset_window), m_ow);
`else
    chk({tag, ".ow"}, int'(onset_window), 0);
`endif
  endtask

  task automatic step(input bit e, input bit lab, input string tag);
    @(negedge clk);
    en = e; predicted_label = lab;
    @(posedge clk);
    model_step(e, lab);
    #1 check_all(tag);
  endtask

  initial begin
    bit lab;
    model_reset();
    // reset held with en toggling and label=1
    predicted_label = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); en = ~en;
      @(posedge clk); #1 check_all("rst_hold");
    end
    @(negedge clk); en = 1'b0; nrst = 1'b1;
    #1 chk("rel_win", int'(window_count), 0);

    // fill: onset only on the 8th window
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, "fill");
    chk("dir_onset_ev", int'(event_count), 1);
    chk("dir_onset_vote", int'(vote_count), 8);
    step(1'b0, 1'b0, "idle1");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, "decay");
    chk("dir_off_pulse_seen", int'(seizure_flag), 0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, "refr");
    chk("dir_ev2", int'(event_count), 2);
    chk("dir_win20", int'(window_count), 20);

    // idle: en=0 with toggling label must hold everything
    for (int i = 0; i < 50; i++) step(1'b0, i[0], "idle");

    // async reset in mid-event
    chk("pre_rst_flag", int'(seizure_flag), 1);
    @(negedge clk); #2 nrst = 1'b0;
    #1 chk("async_flag", int'(seizure_flag), 0);
    chk("async_offp", int'(offset_pulse), 0);
    model_reset();
    @(negedge clk); nrst = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, "refill");
    chk("refill_ev", int'(event_count), 1);

    // randomized runs with bursty labels and occasional reset
    lab = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) lab = ~lab;
      if ($urandom_range(0, 999) == 0) begin
        @(negedge clk); #2 nrst = 1'b0;
        #1 chk("rnd_rst_flag", int'(seizure_flag), 0);
        model_reset();
        @(negedge clk); nrst = 1'b1;
      end
      step($urandom_range(0, 9) < 7, lab, "rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
